// File: rtl/strand_frame_scheduler.sv
// Frame sequencer for NUM_STRANDS strand drivers: periodic tick, start/busy handshake, latch gap, buffer swap.
// Optional SCHED_STAGGER_EN: strand i's start_frame rises i cycles after entering START.
module strand_frame_scheduler #(
  parameter int NUM_STRANDS   = 8,
  parameter int PERIOD_WIDTH  = 24,
  parameter int START_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [NUM_STRANDS-1:0]  strand_enable,
  input  logic [PERIOD_WIDTH-1:0] frame_period,
  input  logic [PERIOD_WIDTH-1:0] latch_cycles,
  input  logic                    swap_req,
  input  logic                    clr_status,
  input  logic [NUM_STRANDS-1:0]  strand_busy,
  output logic [NUM_STRANDS-1:0]  start_frame,
  output logic                    buf_sel,
  output logic                    swap_ack,
  output logic                    frame_done,
  output logic [15:0]             frame_count,
  output logic                    overrun,
  output logic [NUM_STRANDS-1:0]  start_fault,
  output logic                    active
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  localparam logic [PERIOD_WIDTH-1:0] ONE = PERIOD_WIDTH'(1);

  typedef enum logic [2:0] {IDLE, WAIT_TICK, START, RUN, LATCH, SWAP} state_t;

  state_t                  state;
  logic [PERIOD_WIDTH-1:0] timer;
  logic [PERIOD_WIDTH-1:0] gap;
  logic                    tick_pending;
  logic                    tick;
  logic                    start_done;
  logic [NUM_STRANDS-1:0]  mask;
  logic [NUM_STRANDS-1:0]  rise;
  logic [NUM_STRANDS-1:0]  pending;
  logic [NUM_STRANDS-1:0]  timeout;
  logic [NUM_STRANDS-1:0]  start_nxt;
  logic [TW-1:0]           to_cnt [NUM_STRANDS];
`ifdef SCHED_STAGGER_EN
  localparam int SW = $clog2(NUM_STRANDS + 1);
  logic [SW-1:0]           stag_cnt;
`endif

  assign tick = enable && (frame_period != '0) && (timer == '0);

  // A zero period means free-run: a tick is always pending but none is ever counted as overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer        <= '0;
      tick_pending <= 1'b0;
    end else if (!enable) begin
      timer        <= '0;
      tick_pending <= 1'b0;
    end else if (frame_period == '0) begin
      timer        <= '0;
      tick_pending <= 1'b1;
    end else begin
      timer <= (timer == '0) ? frame_period - ONE : timer - ONE;
      if (tick)
        tick_pending <= 1'b1;
      else if (state == WAIT_TICK)
        tick_pending <= 1'b0;
    end
  end

  always_comb begin
    rise    = '0;
    pending = '0;
    timeout = '0;
    for (int i = 0; i < NUM_STRANDS; i++) begin
      timeout[i] = start_frame[i] && !strand_busy[i] && (to_cnt[i] == TW'(START_TIMEOUT - 1));
`ifdef SCHED_STAGGER_EN
      rise[i]    = mask[i] && (stag_cnt == SW'(i));
      pending[i] = mask[i] && (SW'(i) > stag_cnt);
`endif
    end
    start_nxt  = (start_frame & ~strand_busy & ~timeout) | rise;
    start_done = (start_nxt == '0) && (pending == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      mask        <= '0;
      gap         <= '0;
      start_frame <= '0;
      buf_sel     <= 1'b0;
      swap_ack    <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      overrun     <= 1'b0;
      start_fault <= '0;
      active      <= 1'b0;
      for (int i = 0; i < NUM_STRANDS; i++) to_cnt[i] <= '0;
`ifdef SCHED_STAGGER_EN
      stag_cnt    <= '0;
`endif
    end else begin
      swap_ack   <= 1'b0;
      frame_done <= 1'b0;
      if (tick && (tick_pending || (state != WAIT_TICK && state != IDLE)))
        overrun <= 1'b1;
      else if (clr_status)
        overrun <= 1'b0;
      start_fault <= (clr_status ? '0 : start_fault) | ((state == START) ? timeout : '0);

      case (state)
        IDLE: begin
          if (enable) begin
            state  <= WAIT_TICK;
            active <= 1'b1;
          end
        end
        WAIT_TICK: begin
          if (!enable) begin
            state  <= IDLE;
            active <= 1'b0;
          end else if (tick_pending) begin
            mask <= strand_enable;
            for (int i = 0; i < NUM_STRANDS; i++) to_cnt[i] <= '0;
            if (strand_enable == '0) begin
              state <= LATCH;
              gap   <= latch_cycles;
            end else begin
              state <= START;
`ifdef SCHED_STAGGER_EN
              start_frame <= {{(NUM_STRANDS-1){1'b0}}, strand_enable[0]};
              stag_cnt    <= SW'(1);
`else
              start_frame <= strand_enable;
`endif
            end
          end
        end
        START: begin
          start_frame <= start_nxt;
          mask        <= mask & ~timeout;
          for (int i = 0; i < NUM_STRANDS; i++) begin
            if (rise[i])
              to_cnt[i] <= '0;
            else if (start_frame[i])
              to_cnt[i] <= to_cnt[i] + TW'(1);
          end
`ifdef SCHED_STAGGER_EN
          if (stag_cnt != SW'(NUM_STRANDS)) stag_cnt <= stag_cnt + SW'(1);
`endif
          if (start_done) state <= RUN;
        end
        RUN: begin
          if ((strand_busy & mask) == '0) begin
            state <= LATCH;
            gap   <= latch_cycles;
          end
        end
        LATCH: begin
          if (gap == '0) begin
            state       <= SWAP;
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
            if (swap_req) begin
              buf_sel  <= ~buf_sel;
              swap_ack <= 1'b1;
            end
          end else begin
            gap <= gap - ONE;
          end
        end
        SWAP: begin
          if (enable) begin
            state <= WAIT_TICK;
          end else begin
            state  <= IDLE;
            active <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/strand_frame_scheduler.md
Name: strand_frame_scheduler

Overview:
- Sequences frame transmission across NUM_STRANDS strand drivers sharing one frame clock.
- Generates a periodic frame tick and issues per-strand start_frame requests, holding each until that driver's busy is seen.
- Waits for all enabled strands to finish, then enforces a latch/reset gap.
- Swaps the pixel RAM double buffer between frames on host request.

Parameters:
- NUM_STRANDS, 8, number of strand drivers controlled.
- PERIOD_WIDTH, 24, width of frame period and latch gap counters.
- START_TIMEOUT, 16, cycles to wait for a driver's busy after start before flagging it.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  asynchronous active-high reset.
- enable  in  1  scheduler run enable.
- strand_enable  in  NUM_STRANDS  per-strand participation mask, sampled at frame start.
- frame_period  in  PERIOD_WIDTH  cycles between frame ticks; 0 = free-run.
- latch_cycles  in  PERIOD_WIDTH  minimum idle gap after the last strand finishes.
- swap_req  in  1  host level: back buffer is ready.
- clr_status  in  1  pulse; clears sticky flags.
- strand_busy  in  NUM_STRANDS  busy from each driver.
- start_frame  out  NUM_STRANDS  per-driver start request.
- buf_sel  out  1  front buffer select to the pixel RAMs.
- swap_ack  out  1  one-cycle pulse when buf_sel toggles.
- frame_done  out  1  one-cycle pulse at end of latch gap.
- frame_count  out  16  completed frames, wraps at 0xFFFF.
- overrun  out  1  sticky: tick arrived while a frame was in progress.
- start_fault  out  NUM_STRANDS  sticky: strand never asserted busy within START_TIMEOUT.
- active  out  1  high in all states except IDLE.

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, timers 0.
- Frame timer:
  - While enable=1, decrements each cycle. At 0 it reloads frame_period-1 and sets tick_pending.
  - frame_period=0 sets tick_pending permanently.
  - enable=0 clears the timer and tick_pending.
- Overrun: a tick while tick_pending is already set, or while FSM is not WAIT_TICK, sets overrun. The pending tick is retained; ticks are not queued beyond one.
- FSM states:
  - IDLE: active=0. On enable=1, go to WAIT_TICK.
  - WAIT_TICK:
    - enable=0 → IDLE.
    - tick_pending → clear it and latch the mask (strand_enable).
    - Mask all-zero → LATCH. Otherwise → START.
  - START:
    - Assert start_frame[i] for each mask bit.
    - Drop each bit on the first cycle strand_busy[i]=1 (strand_driver samples start only when idle; holding it would retrigger).
    - Per-strand timeout counter: at START_TIMEOUT without busy, drop start_frame[i], set start_fault[i], and remove i from the mask.
    - All bits dropped → RUN.
  - RUN: wait until strand_busy & mask == 0, then → LATCH and load the gap counter with latch_cycles.
  - LATCH: count down to 0 (latch_cycles=0 means 1 cycle), then → SWAP.
  - SWAP (1 cycle):
    - If swap_req=1, toggle buf_sel and pulse swap_ack.
    - Pulse frame_done and increment frame_count.
    - → WAIT_TICK if enable=1, else → IDLE.
- Latencies:
  - tick → start_frame: 2 cycles.
  - Last busy fall → frame_done: latch_cycles+2 cycles.
- enable=0 mid-frame: the current frame completes through SWAP; drivers are never aborted.
- strand_enable changes mid-frame: ignored until the next WAIT_TICK latch.
- Simultaneous clr_status and a set event: set wins.
- buf_sel changes only in SWAP, so it is never mid-frame.

Optional Feature:
- Macro: SCHED_STAGGER_EN.
- Defined:
  - In START, strand i's start_frame rises i cycles after entry, spreading pixel RAM reads and output edge switching.
  - The timeout counter for strand i starts at its own rise.
- Undefined: all masked strands start on the same cycle.

Test Plan:
- Basic frame: NUM_STRANDS=8, mask=0x0F, frame_period=1000, latch_cycles=50, drivers model busy 1 cycle after start for 200 cycles.
  - start_frame=0x0F falls per bit on busy.
  - frame_done occurs 52 cycles after the last busy fall.
  - frame_count=1; next start at cycle 1000+2.
- Overrun: frame_period=100, driver busy 300 cycles → overrun=1 at the first tick during RUN. clr_status → 0.
- Start fault: strand 2 never asserts busy → start_frame[2] drops after 16 cycles, start_fault=0x04, frame still completes.
- Buffer swap: swap_req=1 during RUN → buf_sel toggles and swap_ack pulses in SWAP only. With swap_req=0 → no toggle.
- Async reset mid-RUN: rst pulse → outputs 0 immediately. After release + enable → clean frame with frame_count restarting at 0.
- Stagger (SCHED_STAGGER_EN): mask=0xFF → start_frame[i] rises at START+i. Empty mask → frame_done still pulses, no start_frame.
